// File: rtl/kf8259_interrupt_request_service.sv
// 8259A interrupt request register, in-service register and rotating priority resolver.
// Samples IR pins, picks the winning request and tracks the highest in-service level.
module kf8259_interrupt_request_service (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request_pin,
    input  logic       write_initial_command_word_1,
    input  logic       level_or_edge_toriggered_config,
    input  logic       special_fully_nest_config,
    input  logic       freeze,
    input  logic [7:0] clear_interrupt_request,
    input  logic [7:0] interrupt_mask,
    input  logic [7:0] interrupt_special_mask,
    input  logic [7:0] end_of_interrupt,
    input  logic [2:0] priority_rotate,
    input  logic       latch_in_service,
    output logic [7:0] interrupt,
    output logic [7:0] highest_level_in_service,
    output logic [7:0] interrupt_request_register,
    output logic [7:0] in_service_register
);

    // Rotate so the highest-priority level sits at bit 0, keep the lowest set bit, rotate back.
    function automatic logic [7:0] resolve(input logic [7:0] req, input logic [2:0] rotate);
        logic [2:0] amt;
        logic [7:0] rot_req;
        logic [7:0] low;
        amt     = rotate + 3'd1;
        rot_req = (req >> amt) | (req << (4'd8 - {1'b0, amt}));
        low     = rot_req & (~rot_req + 8'd1);
        return (low << amt) | (low >> (4'd8 - {1'b0, amt}));
    endfunction

    // Priority rank of a one-hot level: 0 = highest priority under the current rotation.
    function automatic logic [2:0] rotated_index(input logic [7:0] level, input logic [2:0] rotate);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (level[i]) idx = 3'(i) - rotate - 3'd1;
        end
        return idx;
    endfunction

    logic [7:0] pin_prev;
    logic [7:0] irr;
    logic [7:0] irr_next;
    logic [7:0] isr;
    logic [7:0] candidate;
    logic [7:0] interrupt_next;
    logic [2:0] candidate_index;
    logic [2:0] in_service_index;
    logic       accept;

    assign interrupt_request_register = irr;
    assign in_service_register        = isr;
    assign highest_level_in_service   = resolve(isr & ~interrupt_special_mask, priority_rotate);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        irr_next = irr;
        for (int i = 0; i < 8; i++) begin
            if (clear_interrupt_request[i])
                irr_next[i] = 1'b0;
            else if (freeze)
                irr_next[i] = irr[i];
            else if (level_or_edge_toriggered_config)
                irr_next[i] = interrupt_request_pin[i];
            else if (interrupt_request_pin[i] && !pin_prev[i])
                irr_next[i] = 1'b1;
            else if (!interrupt_request_pin[i])
                irr_next[i] = 1'b0;
        end
    end

    always_comb begin
        candidate        = resolve(irr & ~interrupt_mask, priority_rotate);
        candidate_index  = rotated_index(candidate, priority_rotate);
        in_service_index = rotated_index(highest_level_in_service, priority_rotate);
        accept           = 1'b0;
        if (candidate != 8'h00) begin
            if (highest_level_in_service == 8'h00)
                accept = 1'b1;
            else if (candidate_index < in_service_index)
                accept = 1'b1;
            else if (special_fully_nest_config && (candidate_index == in_service_index))
                accept = 1'b1;
        end
        interrupt_next = accept ? candidate : 8'h00;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pin_prev  <= 8'h00;
            irr       <= 8'h00;
            isr       <= 8'h00;
            interrupt <= 8'h00;
        end else if (write_initial_command_word_1) begin
            pin_prev  <= 8'h00;
            irr       <= 8'h00;
            isr       <= 8'h00;
            interrupt <= 8'h00;
        end else begin
            pin_prev <= interrupt_request_pin;
            irr      <= irr_next;
            // A bit both cleared by EOI and latched in the same cycle ends up set.
            isr      <= (isr & ~end_of_interrupt) | (latch_in_service ? interrupt : 8'h00);
            if (!freeze)
                interrupt <= interrupt_next;
        end
    end

endmodule

// File: tb/tb_kf8259_interrupt_request_service.sv
// Self-checking bench: a priority-list model of the 8259A request/service logic compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_kf8259_interrupt_request_service;

    logic       clock;
    logic       reset_n;
    logic [7:0] interrupt_request_pin;
    logic       write_initial_command_word_1;
    logic       level_or_edge_toriggered_config;
    logic       special_fully_nest_config;
    logic       freeze;
    logic [7:0] clear_interrupt_request;
    logic [7:0] interrupt_mask;
    logic [7:0] interrupt_special_mask;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic       latch_in_service;
    logic [7:0] interrupt;
    logic [7:0] highest_level_in_service;
    logic [7:0] interrupt_request_register;
    logic [7:0] in_service_register;

    int checks = 0;
    int errors = 0;

    kf8259_interrupt_request_service dut (
        .clock                           (clock),
        .reset_n                         (reset_n),
        .interrupt_request_pin           (interrupt_request_pin),
        .write_initial_command_word_1    (write_initial_command_word_1),
        .level_or_edge_toriggered_config (level_or_edge_toriggered_config),
        .special_fully_nest_config       (special_fully_nest_config),
        .freeze                          (freeze),
        .clear_interrupt_request         (clear_interrupt_request),
        .interrupt_mask                  (interrupt_mask),
        .interrupt_special_mask          (interrupt_special_mask),
        .end_of_interrupt                (end_of_interrupt),
        .priority_rotate                 (priority_rotate),
        .latch_in_service                (latch_in_service),
        .interrupt                       (interrupt),
        .highest_level_in_service        (highest_level_in_service),
        .interrupt_request_register      (interrupt_request_register),
        .in_service_register             (in_service_register)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Priority list: walk levels from (rotate+1) downwards cyclically; first hit wins.
    function automatic int rank_of_first(input logic [7:0] v, input logic [2:0] rot);
        for (int k = 0; k < 8; k++) begin
            if (v[(int'(rot) + 1 + k) % 8]) return k;
        end
        return 8;
    endfunction

    function automatic logic [7:0] level_at_rank(input int k, input logic [2:0] rot);
        logic [7:0] r;
        r = 8'h00;
        if (k < 8) r[(int'(rot) + 1 + k) % 8] = 1'b1;
        return r;
    endfunction

    logic [7:0] m_prev, m_irr, m_isr, m_int;

    function automatic logic [7:0] model_hlis();
        return level_at_rank(rank_of_first(m_isr & ~interrupt_special_mask, priority_rotate),
                             priority_rotate);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        logic [7:0] irr_n;
        int         rc;
        int         rs;
        if (!reset_n) begin
            m_prev <= 8'h00;
            m_irr  <= 8'h00;
            m_isr  <= 8'h00;
            m_int  <= 8'h00;
        end else if (write_initial_command_word_1) begin
            m_prev <= 8'h00;
            m_irr  <= 8'h00;
            m_isr  <= 8'h00;
            m_int  <= 8'h00;
        end else begin
            irr_n = m_irr;
            for (int i = 0; i < 8; i++) begin
                if (clear_interrupt_request[i])            irr_n[i] = 1'b0;
                else if (freeze)                           irr_n[i] = m_irr[i];
                else if (level_or_edge_toriggered_config)  irr_n[i] = interrupt_request_pin[i];
                else if (interrupt_request_pin[i] && !m_prev[i]) irr_n[i] = 1'b1;
                else if (!interrupt_request_pin[i])        irr_n[i] = 1'b0;
            end
            rc = rank_of_first(m_irr & ~interrupt_mask, priority_rotate);
            rs = rank_of_first(m_isr & ~interrupt_special_mask, priority_rotate);
            if (!freeze) begin
                if (rc < 8 && (rc < rs || (special_fully_nest_config && rc == rs)))
                    m_int <= level_at_rank(rc, priority_rotate);
                else
                    m_int <= 8'h00;
            end
            m_prev <= interrupt_request_pin;
            m_irr  <= irr_n;
            m_isr  <= (m_isr & ~end_of_interrupt) | (latch_in_service ? m_int : 8'h00);
        end
    end

    always @(negedge clock) begin
        check("model_interrupt", interrupt, m_int);
        check("model_irr", interrupt_request_register, m_irr);
        check("model_isr", in_service_register, m_isr);
        check("model_hlis", highest_level_in_service, model_hlis());
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_int"}, interrupt, 8'h00);
        check({tag, "_irr"}, interrupt_request_register, 8'h00);
        check({tag, "_isr"}, in_service_register, 8'h00);
        check({tag, "_hlis"}, highest_level_in_service, 8'h00);
    endtask

    task automatic flush();
        interrupt_request_pin   = 8'h00;
        clear_interrupt_request = 8'hFF;
        end_of_interrupt        = 8'hFF;
        interrupt_mask          = 8'h00;
        interrupt_special_mask  = 8'h00;
        tick();
        clear_interrupt_request = 8'h00;
        end_of_interrupt        = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        interrupt_request_pin = 8'h00;
        write_initial_command_word_1 = 1'b0;
        level_or_edge_toriggered_config = 1'b0;
        special_fully_nest_config = 1'b0;
        freeze = 1'b0;
        clear_interrupt_request = 8'h00;
        interrupt_mask = 8'h00;
        interrupt_special_mask = 8'h00;
        end_of_interrupt = 8'h00;
        priority_rotate = 3'd7;
        latch_in_service = 1'b0;
        #3;
        check_all_zero("reset");
        #9 reset_n = 1'b1;
        tick();

        // Edge mode: IR2 and IR5 rise together; IR2 wins at rotate 7.
        interrupt_request_pin = 8'h24;
        tick();
        check("edge_irr", interrupt_request_register, 8'h24);
        check("edge_int_not_yet", interrupt, 8'h00);
        tick();
        check("edge_int", interrupt, 8'h04);

        // Acknowledge IR2: latch into ISR and clear its request; pin stays high.
        latch_in_service = 1'b1;
        clear_interrupt_request = 8'h04;
        tick();
        latch_in_service = 1'b0;
        clear_interrupt_request = 8'h00;
        check("latch_isr", in_service_register, 8'h04);
        check("latch_hlis", highest_level_in_service, 8'h04);
        check("no_retrigger_irr", interrupt_request_register, 8'h20);
        tick();
        check("ir5_blocked", interrupt, 8'h00);

        // IR1 outranks in-service IR2.
        interrupt_request_pin = 8'h26;
        tick();
        tick();
        check("ir1_nests", interrupt, 8'h02);
        clear_interrupt_request = 8'h02;
        interrupt_request_pin = 8'h24;
        tick();
        clear_interrupt_request = 8'h00;
        tick();
        check("ir5_still_blocked", interrupt, 8'h00);
        end_of_interrupt = 8'h04;
        tick();
        end_of_interrupt = 8'h00;
        check("eoi_isr", in_service_register, 8'h00);
        check("eoi_int_same_edge", interrupt, 8'h00);
        tick();
        check("eoi_then_ir5", interrupt, 8'h20);
        flush();

        // Rotation in level mode.
        level_or_edge_toriggered_config = 1'b1;
        interrupt_request_pin = 8'h81;
        tick();
        check("rot_irr", interrupt_request_register, 8'h81);
        priority_rotate = 3'd6;
        tick();
        check("rot6_int", interrupt, 8'h80);
        priority_rotate = 3'd7;
        tick();
        check("rot7_int", interrupt, 8'h01);
        flush();

        // Interrupt mask and special mask.
        interrupt_request_pin = 8'h03;
        interrupt_mask = 8'h01;
        tick();
        tick();
        check("mask_int", interrupt, 8'h02);
        interrupt_mask = 8'h00;
        tick();
        check("unmask_int", interrupt, 8'h01);
        latch_in_service = 1'b1;
        tick();
        latch_in_service = 1'b0;
        check("smask_isr", in_service_register, 8'h01);
        check("smask_hlis_before", highest_level_in_service, 8'h01);
        interrupt_special_mask = 8'h01;
        interrupt_mask = 8'h01;
        #1;
        check("smask_hlis", highest_level_in_service, 8'h00);
        tick();
        check("smask_ir1_accepted", interrupt, 8'h02);
        flush();

        // Special fully nested mode: equal priority in service.
        interrupt_request_pin = 8'h08;
        tick();
        tick();
        check("sfnm_first_int", interrupt, 8'h08);
        latch_in_service = 1'b1;
        tick();
        latch_in_service = 1'b0;
        tick();
        check("sfnm0_blocked", interrupt, 8'h00);
        special_fully_nest_config = 1'b1;
        tick();
        check("sfnm1_accepted", interrupt, 8'h08);
        special_fully_nest_config = 1'b0;
        flush();

        // Freeze in edge mode: an IR2 edge during freeze is lost.
        level_or_edge_toriggered_config = 1'b0;
        interrupt_request_pin = 8'h01;
        tick();
        tick();
        check("pre_freeze_int", interrupt, 8'h01);
        freeze = 1'b1;
        interrupt_request_pin = 8'h05;
        tick();
        check("freeze_irr", interrupt_request_register, 8'h01);
        check("freeze_int", interrupt, 8'h01);
        tick();
        check("freeze_irr_2", interrupt_request_register, 8'h01);
        freeze = 1'b0;
        tick();
        check("edge_lost_irr", interrupt_request_register, 8'h01);

        // ICW1 clears everything synchronously.
        write_initial_command_word_1 = 1'b1;
        tick();
        write_initial_command_word_1 = 1'b0;
        check_all_zero("icw1");

        // Level mode, async reset mid-sequence.
        level_or_edge_toriggered_config = 1'b1;
        interrupt_request_pin = 8'h05;
        tick();
        check("level_irr", interrupt_request_register, 8'h05);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        check_all_zero("after_release");
        tick();
        check("reload_irr", interrupt_request_register, 8'h05);
        tick();
        check("reload_int", interrupt, 8'h01);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
